// File: rtl/mil_tx_arbiter_pkg.sv
// Shared types and default timing for the MIL-STD-1553 transmit arbiter.
package mil_tx_arbiter_pkg;

  localparam int MIL_GAP_CYCLES      = 200;
  localparam int MIL_START_TIMEOUT   = 64;
  localparam int MIL_MAX_BUSY_CYCLES = 40000;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 3'd0;
  localparam arb_state_t ST_GRANT  = 3'd1;
  localparam arb_state_t ST_ACTIVE = 3'd2;
  localparam arb_state_t ST_FAULT  = 3'd3;
  localparam arb_state_t ST_GAP    = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mil_rr_select.sv
// Combinational round-robin picker: first set request after the last owner,
// wrapping modulo N_REQ.
module mil_rr_select #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int unsigned         j;
  logic [IDX_W-1:0]    cand;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    j       = 0;
    cand    = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      j    = (32'(last_i) + k) % N_REQ;
      cand = IDX_W'(j);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/mil_tx_arbiter.sv
// Round-robin owner of one MIL-STD-1553 bus line shared by N_REQ transmitters,
// with turnaround gap, receiver inhibit and start/busy watchdogs.
//
// state  | meaning
// IDLE   | bus free, arbitrating requests
// GRANT  | grant issued, waiting for the owner to go busy
// ACTIVE | owner transmitting (chained words keep busy high)
// FAULT  | busy watchdog fired, waiting for the owner to finish its word
// GAP    | forced bus silence before the next arbitration
module mil_tx_arbiter
  import mil_tx_arbiter_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int GAP_CYCLES      = MIL_GAP_CYCLES,
  parameter int START_TIMEOUT   = MIL_START_TIMEOUT,
  parameter int MAX_BUSY_CYCLES = MIL_MAX_BUSY_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         request_i,
  input  logic [N_REQ-1:0]         busy_i,
  output logic [N_REQ-1:0]         grant_o,
  input  logic                     rx_busy_i,
  input  logic                     enable_i,
  input  logic                     err_clr_i,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     bus_active_o,
  output logic                     start_err_o,
  output logic                     busy_err_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max3(GAP_CYCLES, START_TIMEOUT, MAX_BUSY_CYCLES) + 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             start_err_q, start_err_d;
  logic             busy_err_q, busy_err_d;
  logic             start_set, busy_set;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;

  mil_rr_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_sel (
    .req_i   (request_i),
    .last_i  (owner_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    grant_d   = grant_q;
    owner_d   = owner_q;
    start_set = 1'b0;
    busy_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable_i && !rx_busy_i && sel_valid) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          owner_d          = sel_idx;
          state_d          = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (busy_i[owner_q]) begin
          state_d = ST_ACTIVE;
        end else if (!request_i[owner_q]) begin
          grant_d = '0;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          grant_d   = '0;
          start_set = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_ACTIVE: begin
        if (!busy_i[owner_q]) begin
          grant_d = '0;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_W'(MAX_BUSY_CYCLES - 1)) begin
          grant_d  = '0;
          busy_set = 1'b1;
          state_d  = ST_FAULT;
        end
      end
      ST_FAULT: begin
        // The word in flight cannot be aborted; hold the counter until it ends.
        cnt_d = '0;
        if (!busy_i[owner_q]) state_d = ST_GAP;
      end
      ST_GAP: begin
        grant_d = '0;
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign start_err_d = start_set | (start_err_q & ~err_clr_i);
  assign busy_err_d  = busy_set  | (busy_err_q  & ~err_clr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      owner_q     <= IDX_W'(N_REQ - 1);
      start_err_q <= 1'b0;
      busy_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      start_err_q <= start_err_d;
      busy_err_q  <= busy_err_d;
    end
  end

  assign grant_o      = grant_q;
  assign owner_o      = owner_q;
  assign bus_active_o = (state_q != ST_IDLE);
  assign start_err_o  = start_err_q;
  assign busy_err_o   = busy_err_q;

endmodule

// File: tb/tb_mil_tx_arbiter.sv
// Scoreboarded bench for mil_tx_arbiter: expected grants are queued when a
// request is driven and checked when the grant rises.
module tb_mil_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] request = 2'b00;
  logic [1:0] busy = 2'b00;
  logic [1:0] grant;
  logic       rx_busy = 1'b0;
  logic       enable = 1'b1;
  logic       err_clr = 1'b0;
  logic       owner;
  logic       bus_active;
  logic       start_err;
  logic       busy_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  prev_grant = 2'b00;
  int n;

  always #5 clk = ~clk;

  mil_tx_arbiter #(
    .N_REQ(2), .GAP_CYCLES(4), .START_TIMEOUT(16), .MAX_BUSY_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .request_i(request), .busy_i(busy), .grant_o(grant),
    .rx_busy_i(rx_busy), .enable_i(enable), .err_clr_i(err_clr), .owner_o(owner),
    .bus_active_o(bus_active), .start_err_o(start_err), .busy_err_o(busy_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int idx);
    exp_q.push_back(32'((idx << 2) | (1 << idx)));
  endtask

  task automatic wait_grant(input logic [1:0] m, input int budget, output int cyc);
    cyc = 0;
    while (grant !== m && cyc < budget) begin
      tick(1);
      cyc++;
    end
    if (grant !== m) chk("grant_timeout", 32'(grant), 32'(m));
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (bus_active !== 1'b0 && c < 200) begin
      tick(1);
      c++;
    end
    if (bus_active !== 1'b0) chk("idle_timeout", 32'(bus_active), 0);
  endtask

  // Scoreboard consumer and one-hot invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot0", 32'($onehot0(grant)), 1);
      if (grant !== 2'b00 && prev_grant === 2'b00) begin
        if (exp_q.size() == 0) chk("unexpected_grant", 32'({owner, grant}), 0);
        else chk("sb_grant", 32'({owner, grant}), exp_q.pop_front());
      end
    end
    prev_grant = grant;
  end

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_owner", 32'(owner), 1);
    chk("rst_active", 32'(bus_active), 0);
    chk("rst_errs", 32'({start_err, busy_err}), 0);

    // single requester
    request = 2'b01;
    push_exp(0);
    tick(1);
    chk("t1_latency", 32'(grant), 32'h1);
    tick(9);
    busy = 2'b01;
    tick(1);
    chk("t1_active_grant", 32'(grant), 32'h1);
    tick(5);
    busy = 2'b00;
    request = 2'b00;
    tick(1);
    chk("t1_release", 32'(grant), 0);
    chk("t1_gap_active", 32'(bus_active), 1);
    tick(3);
    chk("t1_gap_still", 32'(bus_active), 1);
    tick(1);
    chk("t1_gap_end", 32'(bus_active), 0);

    // fairness from a fresh reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    request = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push_exp(k % 2);
      wait_grant(2'(1 << (k % 2)), 50, n);
      chk("fair_lat", 32'(n), (k == 0) ? 1 : 5);
      chk("fair_owner", 32'(owner), 32'(k % 2));
      busy = 2'(1 << (k % 2));
      tick(20);
      chk("fair_hold", 32'(grant), 32'(1 << (k % 2)));
      busy = 2'b00;
      tick(1);
      chk("fair_drop", 32'(grant), 0);
    end
    request = 2'b00;
    wait_idle();

    // receiver inhibit
    rx_busy = 1'b1;
    request = 2'b10;
    tick(10);
    chk("rx_inhibit", 32'(grant), 0);
    chk("rx_idle", 32'(bus_active), 0);
    rx_busy = 1'b0;
    push_exp(1);
    tick(1);
    chk("rx_release", 32'(grant), 32'h2);
    request = 2'b00;
    tick(1);
    chk("rx_withdraw", 32'(grant), 0);
    chk("rx_no_err", 32'(start_err), 0);
    wait_idle();

    // start timeout
    request = 2'b01;
    push_exp(0);
    tick(1);
    chk("st_grant", 32'(grant), 32'h1);
    n = 0;
    while (grant === 2'b01 && n < 100) begin
      tick(1);
      n++;
    end
    chk("st_hold_cycles", 32'(n), 16);
    chk("st_err_set", 32'(start_err), 1);
    push_exp(0);
    wait_grant(2'b01, 50, n);
    chk("st_regrant_lat", 32'(n), 5);
    request = 2'b00;
    tick(1);
    chk("st_withdraw", 32'(grant), 0);
    chk("st_err_sticky", 32'(start_err), 1);
    wait_idle();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("st_err_clr", 32'(start_err), 0);

    // busy timeout
    request = 2'b01;
    push_exp(0);
    tick(1);
    chk("bt_grant", 32'(grant), 32'h1);
    busy = 2'b01;
    request = 2'b11;
    tick(1);
    chk("bt_active", 32'(grant), 32'h1);
    n = 0;
    while (grant === 2'b01 && n < 300) begin
      tick(1);
      n++;
    end
    chk("bt_hold_cycles", 32'(n), 100);
    chk("bt_err_set", 32'(busy_err), 1);
    tick(48);
    chk("bt_fault_nogrant", 32'(grant), 0);
    chk("bt_fault_active", 32'(bus_active), 1);
    request = 2'b10;
    busy = 2'b00;
    push_exp(1);
    wait_grant(2'b10, 50, n);
    chk("bt_next_lat", 32'(n), 6);
    request = 2'b00;
    tick(1);
    wait_idle();

    // reset mid-ACTIVE
    request = 2'b01;
    push_exp(0);
    tick(1);
    busy = 2'b01;
    tick(3);
    chk("mr_active", 32'(grant), 32'h1);
    rst = 1'b1;
    request = 2'b00;
    busy = 2'b00;
    tick(1);
    rst = 1'b0;
    chk("mr_grant", 32'(grant), 0);
    chk("mr_owner", 32'(owner), 1);
    chk("mr_flags", 32'({start_err, busy_err, bus_active}), 0);
    request = 2'b01;
    push_exp(0);
    tick(1);
    chk("mr_latency", 32'(grant), 32'h1);
    request = 2'b00;
    tick(1);
    wait_idle();

    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1);
  end

endmodule
